// File: rtl/rgb_pack_writer_pkg.sv
// Shared types for the RGB pack writer.
// Writer state encoding and the clipped 8-bit pixel bundle.
package rgb_pack_writer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      WR0,
      WR1,
      WR2,
      DONE
   } rgb_writer_state_type;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb8_t;

endpackage

// File: rtl/rgb_pack_writer_if.sv
// Pixel stream, frame control and SRAM write port bundle.
// master = writer side (accepts pixels, drives SRAM); slave = environment.
interface rgb_pack_writer_if;

   logic        frame_start;
   logic        pix_valid;
   logic        pix_ready;
   logic [31:0] R_in;
   logic [31:0] G_in;
   logic [31:0] B_in;
   logic        sram_grant;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic        frame_done;

   modport master (
      input  frame_start, pix_valid, R_in, G_in, B_in, sram_grant,
      output pix_ready, SRAM_address, SRAM_write_data,
      output SRAM_we_n, frame_done
   );

   modport slave (
      output frame_start, pix_valid, R_in, G_in, B_in, sram_grant,
      input  pix_ready, SRAM_address, SRAM_write_data,
      input  SRAM_we_n, frame_done
   );

endinterface

// File: rtl/rgb_pack_writer_pixel_fifo.sv
// 4-entry FIFO of clipped pixels; pops a whole pair at once.
// Ports: Clock, resetn, i_flush, i_push, i_pop2, i_data -> o_head, o_head1, o_count.
module rgb_pixel_fifo
   import rgb_pack_writer_pkg::*;
(
   input  logic       Clock,
   input  logic       resetn,
   input  logic       i_flush,
   input  logic       i_push,
   input  logic       i_pop2,
   input  rgb8_t      i_data,
   output rgb8_t      o_head,
   output rgb8_t      o_head1,
   output logic [2:0] o_count
);

   rgb8_t      r_mem [4];
   logic [1:0] r_rd;
   logic [1:0] r_wr;
   logic [2:0] r_count;

   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn) begin
         r_rd    <= 2'd0;
         r_wr    <= 2'd0;
         r_count <= 3'd0;
      end else if (i_flush) begin
         r_rd    <= 2'd0;
         r_wr    <= 2'd0;
         r_count <= 3'd0;
      end else begin
         if (i_push) r_wr <= r_wr + 2'd1;
         if (i_pop2) r_rd <= r_rd + 2'd2;
         r_count <= r_count + {2'b00, i_push}
                  - (i_pop2 ? 3'd2 : 3'd0);
      end
   end

   // Storage needs no reset; count gates every read.
   always_ff @(posedge Clock) begin
      if (i_push && !i_flush) r_mem[r_wr] <= i_data;
   end

   assign o_head  = r_mem[r_rd];
   assign o_head1 = r_mem[r_rd + 2'd1];
   assign o_count = r_count;

endmodule

// File: rtl/rgb_pack_writer.sv
// Clips fixed-point RGB to 8 bits, packs pixel pairs into 3 words, writes SRAM.
// Ports: Clock, resetn, bus (master: pixel stream in, SRAM write port out).
module rgb_pack_writer
   import rgb_pack_writer_pkg::*;
#(
   parameter logic [17:0] RGB_BASE = 18'd146944,
   parameter int          PIXELS   = 76800
) (
   input  logic              Clock,
   input  logic              resetn,
   rgb_pack_writer_if.master bus
);

   localparam int WORDS = 3 * PIXELS / 2;
   localparam int CW    = $clog2(WORDS + 1);
   localparam int PW    = $clog2(PIXELS + 1);

   rgb_writer_state_type r_state;
   rgb_writer_state_type w_next;

   logic [CW-1:0] r_addr_cnt;
   logic [PW-1:0] r_pix_cnt;
   logic [2:0]    w_count;
   rgb8_t         w_pix;
   rgb8_t         w_head;
   rgb8_t         w_head1;
   logic          w_ready;
   logic          w_push;
   logic          w_wr;
   logic          w_pop2;
   logic          w_last;
   logic          w_refill;
   logic [15:0]   w_word;

   // Takes the integer part plus sign of a 16.16 value.
   function automatic logic [7:0] clip8(input logic [15:0] v);
      if (v[15])           return 8'd0;
      else if (|v[14:8])   return 8'd255;
      else                 return v[7:0];
   endfunction

   assign w_pix = {clip8(bus.R_in[31:16]),
                   clip8(bus.G_in[31:16]),
                   clip8(bus.B_in[31:16])};

   // frame_start blocks accept and write so the restart cycle is clean.
   assign w_ready = (r_state != IDLE) && (w_count < 3'd4)
                 && (r_pix_cnt < PW'(PIXELS)) && !bus.frame_start;
   assign w_push  = bus.pix_valid && w_ready;
   assign w_wr    = ((r_state == WR0) || (r_state == WR1)
                 || (r_state == WR2)) && bus.sram_grant
                 && !bus.frame_start;
   assign w_pop2  = w_wr && (r_state == WR2);
   assign w_last  = r_addr_cnt == CW'(WORDS - 1);
   // A full next pair after the pop skips WAIT to sustain 2 px / 3 cycles.
   assign w_refill = ({1'b0, w_count} + {3'b000, w_push}) >= 4'd4;

   assign bus.pix_ready = w_ready;

   rgb_pixel_fifo u_fifo (
      .Clock   (Clock),
      .resetn  (resetn),
      .i_flush (bus.frame_start),
      .i_push  (w_push),
      .i_pop2  (w_pop2),
      .i_data  (w_pix),
      .o_head  (w_head),
      .o_head1 (w_head1),
      .o_count (w_count)
   );

   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_addr_cnt <= '0;
         r_pix_cnt  <= '0;
      end else begin
         r_state <= w_next;
         if (bus.frame_start) begin
            r_addr_cnt <= '0;
            r_pix_cnt  <= '0;
         end else begin
            if (w_wr)   r_addr_cnt <= r_addr_cnt + 1'b1;
            if (w_push) r_pix_cnt  <= r_pix_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      if (bus.frame_start) begin
         w_next = WAIT;
      end else begin
         unique case (r_state)
            IDLE: w_next = IDLE;
            WAIT: if (w_count >= 3'd2) w_next = WR0;
            WR0:  if (bus.sram_grant) w_next = WR1;
            WR1:  if (bus.sram_grant) w_next = WR2;
            WR2: begin
               if (bus.sram_grant) begin
                  if (w_last)        w_next = DONE;
                  else if (w_refill) w_next = WR0;
                  else               w_next = WAIT;
               end
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   always_comb begin
      w_word = 16'h0000;
      unique case (r_state)
         WR0:     w_word = {w_head.r, w_head.g};
         WR1:     w_word = {w_head.b, w_head1.r};
         WR2:     w_word = {w_head1.g, w_head1.b};
         default: w_word = 16'h0000;
      endcase
   end

   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn) begin
         bus.SRAM_address    <= 18'd0;
         bus.SRAM_write_data <= 16'd0;
         bus.SRAM_we_n       <= 1'b1;
         bus.frame_done      <= 1'b0;
      end else begin
         bus.SRAM_we_n  <= !w_wr;
         bus.frame_done <= w_pop2 && w_last;
         if (w_wr) begin
            bus.SRAM_address    <= RGB_BASE + 18'(r_addr_cnt);
            bus.SRAM_write_data <= w_word;
         end
      end
   end

endmodule

// File: tb/tb_rgb_pack_writer.sv
// Scoreboard bench for rgb_pack_writer: directed pixels, queued expected writes.
// Small frame placed so the final word lands on the top SRAM address.
module tb_rgb_pack_writer;

   localparam logic [17:0] BASE = 18'h3FFEE;
   localparam int          NPIX = 12;

   typedef struct packed {
      logic [17:0] a;
      logic [15:0] d;
   } wr_t;

   logic Clock  = 1'b0;
   logic resetn = 1'b0;

   always #5 Clock = ~Clock;

   rgb_pack_writer_if u_if ();

   rgb_pack_writer #(
      .RGB_BASE (BASE),
      .PIXELS   (NPIX)
   ) dut (
      .Clock  (Clock),
      .resetn (resetn),
      .bus    (u_if)
   );

   wr_t         exp_q[$];
   wr_t         mon_e;
   int          n_tests  = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   int          exp_off  = 0;
   logic        have0    = 1'b0;
   logic [23:0] pend;
   logic [17:0] last_wr  = 18'd0;
   logic [17:0] done_addr = 18'd0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Expected bytes are hand-clipped by the caller; this only packs pairs.
   task automatic model_pixel(input logic [23:0] p);
      if (!have0) begin
         pend  = p;
         have0 = 1'b1;
      end else begin
         exp_q.push_back('{a: BASE + 18'(exp_off),
                           d: {pend[23:16], pend[15:8]}});
         exp_q.push_back('{a: BASE + 18'(exp_off + 1),
                           d: {pend[7:0], p[23:16]}});
         exp_q.push_back('{a: BASE + 18'(exp_off + 2),
                           d: {p[15:8], p[7:0]}});
         exp_off += 3;
         have0 = 1'b0;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_off = 0;
      have0   = 1'b0;
   endtask

   task automatic send(input logic [31:0] r, input logic [31:0] g,
                       input logic [31:0] b, input logic [23:0] e);
      logic got;
      got = 1'b0;
      u_if.R_in = r;
      u_if.G_in = g;
      u_if.B_in = b;
      u_if.pix_valid = 1'b1;
      #1;
      for (int i = 0; i < 200; i++) begin
         if (u_if.pix_ready) got = 1'b1;
         @(posedge Clock);
         if (got) break;
         #1;
      end
      #1;
      u_if.pix_valid = 1'b0;
      if (got) model_pixel(e);
      else check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_start();
      u_if.frame_start = 1'b1;
      @(posedge Clock);
      #1;
      u_if.frame_start = 1'b0;
      model_reset();
   endtask

   always @(negedge Clock) begin
      if (resetn && !u_if.SRAM_we_n) begin
         last_wr = u_if.SRAM_address;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, none due",
                     u_if.SRAM_address, u_if.SRAM_write_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(u_if.SRAM_address), 32'(mon_e.a));
            check("wr_data", 32'(u_if.SRAM_write_data), 32'(mon_e.d));
         end
      end
      if (u_if.frame_done) begin
         done_cnt++;
         done_addr = last_wr;
      end
   end

   initial begin
      u_if.frame_start = 1'b0;
      u_if.pix_valid   = 1'b0;
      u_if.R_in        = 32'd0;
      u_if.G_in        = 32'd0;
      u_if.B_in        = 32'd0;
      u_if.sram_grant  = 1'b0;

      repeat (3) @(negedge Clock);
      check("rst_addr", 32'(u_if.SRAM_address), 32'd0);
      check("rst_data", 32'(u_if.SRAM_write_data), 32'd0);
      check("rst_we_n", 32'(u_if.SRAM_we_n), 32'd1);
      check("rst_done", 32'(u_if.frame_done), 32'd0);
      check("rst_ready", 32'(u_if.pix_ready), 32'd0);
      resetn = 1'b1;
      @(posedge Clock);
      #1;

      // Clip corners: words 0x1000, 0x7F50, 0xFF00.
      u_if.sram_grant = 1'b1;
      pulse_start();
      send(32'h00100000, 32'hFFFF0000, 32'h007F8000, 24'h10007F);
      send(32'h00500000, 32'h01000000, 32'h00000000, 24'h50FF00);
      repeat (8) @(posedge Clock);
      #1;

      // Grant stall inside WR1.
      u_if.sram_grant = 1'b0;
      send(32'h00AB0000, 32'h00CD0000, 32'h00EF0000, 24'hABCDEF);
      send(32'h80000000, 32'h7FFFFFFF, 32'h00010000, 24'h00FF01);
      repeat (3) @(posedge Clock);
      #1;
      u_if.sram_grant = 1'b1;
      @(posedge Clock);
      #1;
      check("stall_w0_we_n", 32'(u_if.SRAM_we_n), 32'd0);
      u_if.sram_grant = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock);
         #1;
         check("stall_we_n", 32'(u_if.SRAM_we_n), 32'd1);
      end
      u_if.sram_grant = 1'b1;
      repeat (6) @(posedge Clock);
      #1;

      // Backpressure: fill the FIFO with no grant.
      u_if.sram_grant = 1'b0;
      for (int k = 5; k <= 8; k++)
         send({8'h00, 8'(k * 17), 16'h8000},
              {8'h00, 8'(255 - k), 16'h0001},
              (k % 2 == 1) ? 32'hF0000000 : 32'h02000000,
              {8'(k * 17), 8'(255 - k), (k % 2 == 1) ? 8'h00 : 8'hFF});
      u_if.R_in = {8'h00, 8'(9 * 17), 16'h8000};
      u_if.G_in = {8'h00, 8'(255 - 9), 16'h0001};
      u_if.B_in = 32'hF0000000;
      u_if.pix_valid = 1'b1;
      #1;
      check("bp_ready_full", 32'(u_if.pix_ready), 32'd0);
      u_if.sram_grant = 1'b1;
      @(posedge Clock);
      #1;
      check("bp_ready_wr0", 32'(u_if.pix_ready), 32'd0);
      @(posedge Clock);
      #1;
      check("bp_ready_wr1", 32'(u_if.pix_ready), 32'd0);
      @(posedge Clock);
      #1;
      check("bp_ready_pop", 32'(u_if.pix_ready), 32'd1);
      for (int k = 9; k <= 12; k++)
         send({8'h00, 8'(k * 17), 16'h8000},
              {8'h00, 8'(255 - k), 16'h0001},
              (k % 2 == 1) ? 32'hF0000000 : 32'h02000000,
              {8'(k * 17), 8'(255 - k), (k % 2 == 1) ? 8'h00 : 8'hFF});
      u_if.pix_valid = 1'b1;
      #1;
      check("ready_after_last", 32'(u_if.pix_ready), 32'd0);
      u_if.pix_valid = 1'b0;
      for (int i = 0; i < 60 && done_cnt == 0; i++) @(posedge Clock);
      repeat (4) @(posedge Clock);
      #1;
      check("frame_done_cnt", 32'(done_cnt), 32'd1);
      check("last_addr", 32'(done_addr), 32'h3FFFF);
      check("frame_drained", 32'(exp_q.size()), 32'd0);

      // Mid-frame restart after 3 pixels.
      pulse_start();
      u_if.sram_grant = 1'b0;
      send(32'h00010000, 32'h00020000, 32'h00030000, 24'h010203);
      send(32'h00040000, 32'h00050000, 32'h00060000, 24'h040506);
      send(32'h00070000, 32'h00080000, 32'h00090000, 24'h070809);
      u_if.frame_start = 1'b1;
      u_if.R_in = 32'h00EE0000;
      u_if.G_in = 32'h00EE0000;
      u_if.B_in = 32'h00EE0000;
      u_if.pix_valid = 1'b1;
      #1;
      check("restart_ready", 32'(u_if.pix_ready), 32'd0);
      @(posedge Clock);
      #1;
      u_if.frame_start = 1'b0;
      u_if.pix_valid = 1'b0;
      model_reset();
      u_if.sram_grant = 1'b1;
      send(32'h00C80000, 32'h00640000, 32'hFFFFFFFF, 24'hC86400);
      send(32'h7F000000, 32'h0012FFFF, 32'h00340000, 24'hFF1234);
      repeat (8) @(posedge Clock);
      #1;
      check("restart_drained", 32'(exp_q.size()), 32'd0);

      // Reset during WR1.
      send(32'h00110000, 32'h00220000, 32'h00330000, 24'h112233);
      send(32'h00440000, 32'h00550000, 32'h00660000, 24'h445566);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clock);
            if (!u_if.SRAM_we_n) seen = 1'b1;
         end
         check("rst_mid_seen_w0", 32'(seen), 32'd1);
      end
      #1;
      resetn = 1'b0;
      @(posedge Clock);
      #1;
      check("midrst_addr", 32'(u_if.SRAM_address), 32'd0);
      check("midrst_data", 32'(u_if.SRAM_write_data), 32'd0);
      check("midrst_we_n", 32'(u_if.SRAM_we_n), 32'd1);
      check("midrst_done", 32'(u_if.frame_done), 32'd0);
      check("midrst_ready", 32'(u_if.pix_ready), 32'd0);
      model_reset();
      @(negedge Clock);
      resetn = 1'b1;
      u_if.pix_valid = 1'b1;
      repeat (10) @(posedge Clock);
      #1;
      check("post_rst_ready", 32'(u_if.pix_ready), 32'd0);
      u_if.pix_valid = 1'b0;
      check("done_total", 32'(done_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
